// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the IF/ID hazard controller.
package pipe_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP       = 32'h0;
  localparam int          CNT_W_DEF = 16;
  localparam int          MDU_CNT_W = 4;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute hazard inputs and pipeline-control outputs of hazard_ctrl.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_Rt;
  logic [4:0]       IFID_Rs;
  logic [4:0]       IFID_Rt;
  logic             IFID_UsesRt;
  logic             IFID_MduOp;
  logic             IFID_ReadsHiLo;
  logic             branch_taken;
  logic             jump;
  logic             imem_ready;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFID_flush;
  logic             IDEX_bubble;
  logic             mdu_start;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_MduOp,
           IFID_ReadsHiLo, branch_taken, jump, imem_ready,
    input  PCWrite, IFIDWrite, IFID_flush, IDEX_bubble, mdu_start, mdu_busy,
           stall_cycles, flush_count
  );

  modport slave (
    input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_MduOp,
           IFID_ReadsHiLo, branch_taken, jump, imem_ready,
    output PCWrite, IFIDWrite, IFID_flush, IDEX_bubble, mdu_start, mdu_busy,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset)                        r_count <= '0;
    else if (i_inc && (r_count != '1)) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID hazard controller: load-use and MDU stalls, redirect flushes,
// imem-wait NOP insertion, MDU occupancy tracking and perf counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic         clock,
  input logic         reset,
  hazard_ctrl_if.slave hif
);
  mdu_state_t           r_state, w_state_nxt;
  logic [MDU_CNT_W-1:0] r_mdu_cnt, w_cnt_nxt;

  logic w_load_use, w_mdu_hazard, w_stall_id, w_redirect, w_mdu_start;
  logic w_stall_inc, w_flush_inc;

  assign w_load_use = hif.IDEX_MemRead && (hif.IDEX_Rt != REG_ZERO) &&
                      ((hif.IDEX_Rt == hif.IFID_Rs) ||
                       (hif.IFID_UsesRt && (hif.IDEX_Rt == hif.IFID_Rt)));
  assign w_mdu_hazard = (r_state == BUSY) && (hif.IFID_MduOp || hif.IFID_ReadsHiLo);
  assign w_stall_id   = w_load_use || w_mdu_hazard;
  assign w_redirect   = hif.branch_taken || hif.jump;
  assign w_mdu_start  = !reset && (r_state == IDLE) && hif.IFID_MduOp && !w_stall_id;

  // MDU FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mdu_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mdu_cnt <= w_cnt_nxt;
    end
  end

  // MDU FSM: next state; the counter holds the remaining busy cycles minus one
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_mdu_cnt;
    case (r_state)
      IDLE: if (w_mdu_start) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = MDU_CNT_W'(MDU_LATENCY - 1);
      end
      BUSY: if (r_mdu_cnt == '0) w_state_nxt = IDLE;
            else                 w_cnt_nxt   = r_mdu_cnt - 1'b1;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: stall beats redirect beats imem wait, so a redirect is never lost
  always_comb begin
    hif.PCWrite     = 1'b1;
    hif.IFIDWrite   = 1'b1;
    hif.IFID_flush  = 1'b0;
    hif.IDEX_bubble = 1'b0;
    if (reset) begin
      hif.PCWrite     = 1'b0;
      hif.IFIDWrite   = 1'b0;
      hif.IFID_flush  = 1'b1;
      hif.IDEX_bubble = 1'b1;
    end else if (w_stall_id) begin
      hif.PCWrite     = 1'b0;
      hif.IFIDWrite   = 1'b0;
      hif.IDEX_bubble = 1'b1;
    end else if (w_redirect) begin
      hif.IFID_flush  = 1'b1;
    end else if (!hif.imem_ready) begin
      hif.PCWrite     = 1'b0;
      hif.IFID_flush  = 1'b1;
    end
    hif.mdu_start = w_mdu_start;
    hif.mdu_busy  = !reset && (r_state == BUSY);
  end

  assign w_stall_inc = w_stall_id || (!hif.imem_ready && !w_redirect);
  assign w_flush_inc = !w_stall_id && w_redirect;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_inc  (w_stall_inc),
    .o_count(hif.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_inc  (w_flush_inc),
    .o_count(hif.flush_count)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus random checks of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .hif  (hif.slave)
  );

  int errs   = 0;
  int checks = 0;
  // model state: cycles of MDU occupancy still ahead, and the two counters
  int m_busy_left = 0;
  int m_sc = 0;
  int m_fc = 0;
  int start_at;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic drv(input bit mr, input int exrt, input int rs, input int rt,
                     input bit ur, input bit mop, input bit hl, input bit br,
                     input bit jp, input bit imr);
    hif.IDEX_MemRead = mr;       hif.IDEX_Rt = 5'(exrt);
    hif.IFID_Rs = 5'(rs);        hif.IFID_Rt = 5'(rt);
    hif.IFID_UsesRt = ur;        hif.IFID_MduOp = mop;
    hif.IFID_ReadsHiLo = hl;     hif.branch_taken = br;
    hif.jump = jp;               hif.imem_ready = imr;
  endtask

  // One clock: check mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit lu, stall, redir, busy, start;
    bit e_pc, e_ifw, e_fl, e_bub;
    @(negedge clock);
    lu    = hif.IDEX_MemRead && hif.IDEX_Rt != 0 &&
            (hif.IDEX_Rt == hif.IFID_Rs || (hif.IFID_UsesRt && hif.IDEX_Rt == hif.IFID_Rt));
    busy  = m_busy_left > 0;
    stall = lu || (busy && (hif.IFID_MduOp || hif.IFID_ReadsHiLo));
    redir = hif.branch_taken || hif.jump;
    start = !reset && !busy && hif.IFID_MduOp && !stall;
    if (reset)      {e_pc, e_ifw, e_fl, e_bub} = 4'b0011;
    else if (stall) {e_pc, e_ifw, e_fl, e_bub} = 4'b0001;
    else if (redir) {e_pc, e_ifw, e_fl, e_bub} = 4'b1110;
    else if (!hif.imem_ready) {e_pc, e_ifw, e_fl, e_bub} = 4'b0110;
    else            {e_pc, e_ifw, e_fl, e_bub} = 4'b1100;
    chk("PCWrite",      32'(hif.PCWrite),     32'(e_pc));
    chk("IFIDWrite",    32'(hif.IFIDWrite),   32'(e_ifw));
    chk("IFID_flush",   32'(hif.IFID_flush),  32'(e_fl));
    chk("IDEX_bubble",  32'(hif.IDEX_bubble), 32'(e_bub));
    chk("mdu_start",    32'(hif.mdu_start),   32'(start));
    chk("mdu_busy",     32'(hif.mdu_busy),    32'(busy && !reset));
    chk("stall_cycles", 32'(hif.stall_cycles), 32'(m_sc));
    chk("flush_count",  32'(hif.flush_count),  32'(m_fc));
    if (reset) begin
      m_busy_left = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (busy)       m_busy_left--;
      else if (start) m_busy_left = LAT;
      if ((stall || (!hif.imem_ready && !redir)) && m_sc < CMAX) m_sc++;
      if (!stall && redir && m_fc < CMAX) m_fc++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();

    // load-use on rs: exactly one stall cycle
    drv(1, 8, 8, 0, 0, 0, 0, 0, 0, 1); cycle();
    drv(0, 8, 8, 0, 0, 0, 0, 0, 0, 1); cycle();
    chk("lu_stall_count", 32'(hif.stall_cycles), 32'd1);

    // $zero and rt filtering
    drv(1, 0, 0, 0, 1, 0, 0, 0, 0, 1); cycle();
    drv(1, 9, 1, 9, 0, 0, 0, 0, 0, 1); cycle();
    drv(1, 9, 1, 9, 1, 0, 0, 0, 0, 1); cycle();
    chk("rt_stall_count", 32'(hif.stall_cycles), 32'd2);

    // branch with imem wait: redirect wins, no stall counted
    do_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
    chk("br_wait_flush", 32'(hif.flush_count), 32'd1);
    chk("br_wait_stall", 32'(hif.stall_cycles), 32'd0);

    // branch during load-use: stall first, flush next cycle
    drv(1, 8, 8, 0, 0, 0, 0, 1, 0, 1); cycle();
    drv(0, 8, 8, 0, 0, 0, 0, 1, 0, 1); cycle();
    chk("br_lu_flush", 32'(hif.flush_count), 32'd2);

    // back-to-back MDU: second op issues at cycle LAT+1
    do_reset();
    start_at = -1;
    for (int c = 0; c < 8; c++) begin
      drv(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      if (c > 0 && start_at < 0) begin
        #3;
        if (hif.mdu_start) start_at = c;
      end
      cycle();
    end
    chk("mdu_reissue_cycle", 32'(start_at), 32'(LAT + 1));

    // reset mid-BUSY aborts the operation
    do_reset();
    drv(0, 0, 0, 0, 0, 1, 0, 0, 0, 1); cycle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
    do_reset();
    #3;
    chk("rst_busy", 32'(hif.mdu_busy), 32'd0);
    chk("rst_sc",   32'(hif.stall_cycles), 32'd0);

    // saturation: 20 imem-wait cycles on a 4-bit counter
    for (int c = 0; c < 20; c++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    end
    chk("sat_stall", 32'(hif.stall_cycles), 32'hF);

    // random traffic with small register indices to provoke hazards
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      drv(($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0));
      cycle();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
